// File: rtl/audio_pkg.sv
// Shared voice-path types and constants (envelope states, sample divider, envelope ceiling).
// ENVGEN_EXP_EN selects the level-proportional decay/release step helper used by envelope_gen.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int          SAMPLE_DIV = 256;
  localparam logic [15:0] ENV_MAX    = 16'hFFFF;

  // Step shrinks with the current gain so the tail falls off roughly exponentially.
  function automatic logic [16:0] exp_step(input logic [7:0] gain, input logic [7:0] rate);
    logic [16:0] prod;
    prod = (({9'd0, gain} + 17'd1) * {9'd0, rate}) >> 4;
    return (prod == 17'd0) ? 17'd1 : prod;
  endfunction

endpackage

// File: rtl/env_scale.sv
// Registered gain stage: unsigned oscillator sample -> signed sample scaled by an 8-bit gain.
module env_scale #(
  parameter int BITDEPTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [BITDEPTH-1:0] osc,
  input  logic [7:0]          gain,
  output logic [BITDEPTH-1:0] audio
);

  localparam int PW = BITDEPTH + 9;

  logic [PW-1:0] s_ext, g_ext, p;
  logic          unused_bits;

  // Flipping the MSB turns offset-binary into two's complement; sign-extend to full product width
  // so the low PW bits of an unsigned multiply equal the signed product.
  assign s_ext       = {{9{~osc[BITDEPTH-1]}}, ~osc[BITDEPTH-1], osc[BITDEPTH-2:0]};
  assign g_ext       = {{(BITDEPTH+1){1'b0}}, gain};
  assign p           = s_ext * g_ext;
  assign unused_bits = ^{p[PW-1], p[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  audio <= '0;
    else if (en) audio <= p[BITDEPTH+7:8];
  end

endmodule

// File: rtl/envelope_gen.sv
// Per-voice ADSR envelope: sample tick detect, ADSR FSM and gain stage feeding the mixer.
// Define ENVGEN_EXP_EN for exponential-like decay/release; default build is linear.
module envelope_gen
  import audio_pkg::*;
#(
  parameter int BITDEPTH = 12,
  parameter int ENVBITS  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clock,
  input  logic [BITDEPTH-1:0] osc_in,
  input  logic                gate,
  input  logic [7:0]          attack_rate,
  input  logic [7:0]          decay_rate,
  input  logic [7:0]          sustain_level,
  input  logic [7:0]          release_rate,
  output logic [BITDEPTH-1:0] audio_out,
  output logic                out_valid,
  output logic [7:0]          env_level,
  output logic                active
);

  localparam int               STAGES  = 2;
  localparam logic [ENVBITS:0] ENV_TOP = {1'b0, ENV_MAX};

  logic [1:0]          sc_sync;
  logic                tick;
  logic [STAGES-1:0]   vld_pipe;
  env_state_t          state;
  logic [ENVBITS-1:0]  env;
  logic                gate_q;
  logic [BITDEPTH-1:0] osc_q;
  logic [7:0]          gain;

  logic [ENVBITS:0] env_w, sus_w, step_d, step_r, atk_sum, dec_sum, rel_sum;
  logic             atk_done, dec_done, rel_done;

  assign gain      = env[ENVBITS-1 -: 8];
  assign tick      = sc_sync[0] & ~sc_sync[1];
  assign out_valid = vld_pipe[STAGES-1];
  assign env_level = gain;
  assign active    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_sync  <= '0;
      vld_pipe <= '0;
    end else begin
      sc_sync  <= {sc_sync[0], sample_clock};
      vld_pipe <= {vld_pipe[STAGES-2:0], tick};
    end
  end

  // One extra bit of headroom: carry out flags overflow on attack, MSB flags underflow on decay/release.
  always_comb begin
    env_w = {1'b0, env};
    sus_w = {1'b0, sustain_level, {(ENVBITS-8){1'b0}}};
`ifdef ENVGEN_EXP_EN
    step_d = exp_step(gain, decay_rate);
    step_r = exp_step(gain, release_rate);
`else
    step_d = {{(ENVBITS-7){1'b0}}, decay_rate};
    step_r = {{(ENVBITS-7){1'b0}}, release_rate};
`endif
    atk_sum  = env_w + {{(ENVBITS-7){1'b0}}, attack_rate};
    dec_sum  = env_w - step_d;
    rel_sum  = env_w - step_r;
    atk_done = (attack_rate == 8'd0) || (atk_sum >= ENV_TOP);
    dec_done = (decay_rate == 8'd0) || dec_sum[ENVBITS] || (dec_sum <= sus_w);
    rel_done = (release_rate == 8'd0) || rel_sum[ENVBITS] || (rel_sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      env    <= '0;
      gate_q <= 1'b0;
      osc_q  <= '0;
    end else if (tick) begin
      gate_q <= gate;
      osc_q  <= osc_in;
      // Retrigger keeps the current level so a re-gated note does not click.
      if (gate && !gate_q) begin
        state <= ATTACK;
      end else if (!gate && (state inside {ATTACK, DECAY, SUSTAIN})) begin
        state <= RELEASE;
      end else begin
        case (state)
          ATTACK: begin
            if (atk_done) begin
              env   <= ENV_MAX;
              state <= DECAY;
            end else begin
              env <= atk_sum[ENVBITS-1:0];
            end
          end
          DECAY: begin
            if (dec_done) begin
              env   <= sus_w[ENVBITS-1:0];
              state <= SUSTAIN;
            end else begin
              env <= dec_sum[ENVBITS-1:0];
            end
          end
          SUSTAIN: env <= sus_w[ENVBITS-1:0];
          RELEASE: begin
            if (rel_done) begin
              env   <= '0;
              state <= IDLE;
            end else begin
              env <= rel_sum[ENVBITS-1:0];
            end
          end
          default: env <= '0;
        endcase
      end
    end
  end

  env_scale #(.BITDEPTH(BITDEPTH)) u_scale (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (vld_pipe[0]),
    .osc   (osc_q),
    .gain  (gain),
    .audio (audio_out)
  );

endmodule

// File: tb/tb_envelope_gen.sv
// Self-checking bench for envelope_gen against a behavioural ADSR model.
module tb_envelope_gen;

  logic        clk, rst_n, sample_clock, gate;
  logic [11:0] osc_in;
  logic [7:0]  attack_rate, decay_rate, sustain_level, release_rate;
  logic [11:0] audio_out;
  logic        out_valid, active;
  logic [7:0]  env_level;

  envelope_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_clock  (sample_clock),
    .osc_in        (osc_in),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .audio_out     (audio_out),
    .out_valid     (out_valid),
    .env_level     (env_level),
    .active        (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  string tname = "";

  localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;
  int m_env = 0;
  int m_st  = M_IDLE;
  bit m_gq  = 1'b0;

  function automatic int step_of(int rate);
`ifdef ENVGEN_EXP_EN
    int s;
    s = (((m_env / 256) + 1) * rate) / 16;
    return (s < 1) ? 1 : s;
`else
    return rate;
`endif
  endfunction

  function automatic int scaled(int osc, int env);
    int s, p;
    s = osc - 2048;
    p = s * (env / 256);
    return (p >>> 8) & 'hFFF;
  endfunction

  task automatic model_reset();
    m_env = 0;
    m_st  = M_IDLE;
    m_gq  = 1'b0;
  endtask

  task automatic model_tick();
    int sus, st;
    sus = int'(sustain_level) * 256;
    if (gate && !m_gq) m_st = M_ATK;
    else if (!gate && (m_st == M_ATK || m_st == M_DEC || m_st == M_SUS)) m_st = M_REL;
    else begin
      case (m_st)
        M_ATK: if (attack_rate == 0 || m_env + int'(attack_rate) >= 65535) begin
                 m_env = 65535; m_st = M_DEC;
               end else m_env = m_env + int'(attack_rate);
        M_DEC: begin
                 st = step_of(int'(decay_rate));
                 if (decay_rate == 0 || m_env - st <= sus) begin m_env = sus; m_st = M_SUS; end
                 else m_env = m_env - st;
               end
        M_SUS: m_env = sus;
        M_REL: begin
                 st = step_of(int'(release_rate));
                 if (release_rate == 0 || m_env - st <= 0) begin m_env = 0; m_st = M_IDLE; end
                 else m_env = m_env - st;
               end
        default: m_env = 0;
      endcase
    end
    m_gq = gate;
  endtask

  // One sample_clock period of 8 clk; two sync flops plus the 2-clk pipeline put out_valid
  // on the third rising clk edge after sample_clock rises.
  task automatic run_period();
    @(negedge clk);
    sample_clock = 1'b1;
    model_tick();
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'(k == 3)) begin
        failures++;
        $display("FAIL %s out_valid k=%0d got %b exp %b", tname, k, out_valid, (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (audio_out !== 12'(scaled(int'(osc_in), m_env))) begin
          failures++;
          $display("FAIL %s audio_out got %h exp %h", tname, audio_out, 12'(scaled(int'(osc_in), m_env)));
        end
        checks++;
        if (env_level !== 8'(m_env / 256)) begin
          failures++;
          $display("FAIL %s env_level got %h exp %h", tname, env_level, 8'(m_env / 256));
        end
        checks++;
        if (active !== (m_st != M_IDLE)) begin
          failures++;
          $display("FAIL %s active got %b exp %b", tname, active, (m_st != M_IDLE));
        end
      end
      if (k == 4) sample_clock = 1'b0;
    end
  endtask

  task automatic test_reset();
    tname = "reset";
    rst_n = 1'b0; sample_clock = 1'b0; gate = 1'b0; osc_in = '0;
    attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({audio_out, env_level, active, out_valid} !== 22'd0) begin
      failures++;
      $display("FAIL reset outputs got audio=%h env=%h act=%b vld=%b exp 0", audio_out, env_level, active, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_attack();
    int n;
    bit done;
    tname = "attack";
    osc_in = 12'hFFF; gate = 1'b1;
    attack_rate = 8'd255; decay_rate = 8'd16; sustain_level = 8'h80; release_rate = 8'd32;
    n = 0; done = 1'b0;
    while (!done && n < 400) begin
      run_period();
      n++;
      if (env_level == 8'hFF) done = 1'b1;
    end
    // gate-edge tick holds level, then 256 steps of 255 reach 0xFF00
    checks++;
    if (n !== 257) begin failures++; $display("FAIL attack_periods_to_ff got %0d exp 257", n); end
    run_period();
    checks++;
    if (audio_out !== 12'h7F7) begin failures++; $display("FAIL attack_full_scale got %h exp 7f7", audio_out); end
  endtask

  task automatic test_decay_sustain();
    int n;
    tname = "decay";
    n = 0;
    while (m_st != M_SUS && n < 5000) begin run_period(); n++; end
    checks++;
    if (env_level !== 8'h80) begin failures++; $display("FAIL sustain_level got %h exp 80", env_level); end
    osc_in = 12'h000;
    run_period();
    checks++;
    if (audio_out !== 12'hC00) begin failures++; $display("FAIL sustain_neg_full got %h exp c00", audio_out); end
    sustain_level = 8'h40;
    run_period();
    checks++;
    if (env_level !== 8'h40) begin failures++; $display("FAIL sustain_track got %h exp 40", env_level); end
  endtask

  task automatic test_release();
    int n;
    tname = "release";
    gate = 1'b0; release_rate = 8'd32;
    n = 0;
    while (active && n < 2000) begin osc_in = 12'($urandom); run_period(); n++; end
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL release_idle active got %b exp 0", active); end
`ifndef ENVGEN_EXP_EN
    // one tick enters RELEASE, then 0x4000/32 = 512 linear steps
    checks++;
    if (n !== 513) begin failures++; $display("FAIL release_periods got %0d exp 513", n); end
`endif
  endtask

  task automatic test_regate();
    int n;
    tname = "regate";
    gate = 1'b1; attack_rate = 8'd255; decay_rate = 8'd255; sustain_level = 8'h40;
    n = 0;
    while (m_st != M_SUS && n < 1000) begin osc_in = 12'($urandom); run_period(); n++; end
    gate = 1'b0; release_rate = 8'd16;
    n = 0;
    do begin osc_in = 12'($urandom); run_period(); n++; end while (env_level != 8'h30 && n < 2000);
    checks++;
    if (env_level !== 8'h30) begin failures++; $display("FAIL regate_reach30 got %h exp 30", env_level); end
    gate = 1'b1; attack_rate = 8'd8;
    run_period();
    checks++;
    if (env_level !== 8'h30 || active !== 1'b1) begin
      failures++;
      $display("FAIL regate_hold got env=%h act=%b exp env=30 act=1", env_level, active);
    end
    run_period();
    checks++;
    if (env_level < 8'h30) begin failures++; $display("FAIL regate_rise got %h exp >=30", env_level); end
  endtask

  task automatic test_rates_zero();
    tname = "rates0";
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 8'h20; release_rate = 8'd0;
    run_period();
    checks++;
    if (env_level !== 8'hFF) begin failures++; $display("FAIL rate0_attack got %h exp ff", env_level); end
    run_period();
    checks++;
    if (env_level !== 8'h20) begin failures++; $display("FAIL rate0_decay got %h exp 20", env_level); end
    gate = 1'b0;
    run_period();
    checks++;
    if (env_level !== 8'h20 || active !== 1'b1) begin
      failures++;
      $display("FAIL rate0_rel_entry got env=%h act=%b exp env=20 act=1", env_level, active);
    end
    run_period();
    checks++;
    if (env_level !== 8'h00 || active !== 1'b0) begin
      failures++;
      $display("FAIL rate0_release got env=%h act=%b exp env=00 act=0", env_level, active);
    end
  endtask

`ifdef ENVGEN_EXP_EN
  task automatic test_exp_release();
    int n;
    logic [7:0] prev;
    bit mono;
    tname = "exp";
    gate = 1'b1; attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 8'hFF; release_rate = 8'd16;
    run_period();
    run_period();
    checks++;
    if (env_level !== 8'hFF) begin failures++; $display("FAIL exp_start got %h exp ff", env_level); end
    gate = 1'b0;
    run_period();
    prev = env_level; mono = 1'b1; n = 0;
    while (active && n < 4096) begin
      osc_in = 12'($urandom);
      run_period();
      n++;
      if (env_level > prev) mono = 1'b0;
      prev = env_level;
    end
    checks++;
    if (n >= 4096 || active !== 1'b0) begin failures++; $display("FAIL exp_release_len got %0d exp <4096", n); end
    checks++;
    if (!mono) begin failures++; $display("FAIL exp_release_monotonic got rising level exp non-increasing"); end
  endtask
`endif

  task automatic test_random();
    tname = "random";
    for (int i = 0; i < 400; i++) begin
      osc_in = 12'($urandom);
      if ($urandom_range(0, 15) == 0) gate = ~gate;
      if ($urandom_range(0, 3) == 0) begin
        attack_rate   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        decay_rate    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        release_rate  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        sustain_level = 8'($urandom);
      end
      run_period();
    end
  endtask

  task automatic test_reset_mid_attack();
    tname = "reset_mid";
    osc_in = 12'hFFF; gate = 1'b0; release_rate = 8'd0;
    run_period();
    run_period();
    gate = 1'b1; attack_rate = 8'd255;
    repeat (4) run_period();
    checks++;
    if (env_level !== 8'd2 || active !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got env=%h act=%b exp env=02 act=1", env_level, active);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({audio_out, env_level, active, out_valid} !== 22'd0) begin
      failures++;
      $display("FAIL reset_mid outputs got audio=%h env=%h act=%b vld=%b exp 0", audio_out, env_level, active, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_regate();
    test_rates_zero();
`ifdef ENVGEN_EXP_EN
    test_exp_release();
`endif
    test_random();
    test_reset_mid_attack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
